pckengen: RTL and testbench
===========================

# pckengen

Multi-channel fractional pixel-clock-enable generator, successor to the fixed single-MMCM pixel clock.
- Runs entirely on SYSCLK (125 MHz). Each of NCH channels produces a one-cycle pixel strobe PCE at a runtime-selectable video rate using a phase accumulator.
- Each channel also drives a pixel-domain reset, PRST, that is sequenced around every rate change.
- Sits between the clocking front end and the per-display timing generators; no MMCM or BUFG is consumed per mode.

## Interface
Parameters:
- NCH, 2, number of independent channels
- ACC_W, 32, phase-accumulator width in bits
- RST_STB, 16, number of new-rate strobes PRST stays high after reset or a mode change
- DEFAULT_MODE, 0, mode loaded on reset (0–3)
- GATE_CYC, 125000000, measurement window in SYSCLK cycles (only when PCKENGEN_FREQ_EN is defined)

Ports:
- SYSCLK  in  1  the single clock (125 MHz)
- RST  in  1  reset, synchronous, active-high
- MODE  in  2*NCH  requested mode; channel c uses bits [2c+1:2c]
- REQ  in  NCH  per-channel one-cycle mode-change request
- ACK  out  NCH  one-cycle pulse when the new mode is running
- BUSY  out  NCH  high while a channel is not in RUN
- PCE  out  NCH  pixel strobe, one SYSCLK cycle wide
- PRST  out  NCH  pixel-domain reset, active-high
- FREQ  out  NCH*28  strobes counted in the last window (only when PCKENGEN_FREQ_EN is defined)

## Operation
Mode table (increment = round(f/125 MHz · 2^32), scaled to ACC_W):
- 0: 25.175 MHz, 865006413
- 1: 27.000 MHz, 927712936
- 2: 40.000 MHz, 1374389535
- 3: 65.000 MHz, 2233382994

Accumulator:
- Every cycle: acc <= acc + inc (ACC_W bits, wraps).
- The carry-out of that add is the raw strobe.
- Rates above f/2 legally produce strobes on consecutive cycles.

Per-channel FSM:
- HOLD: accumulator running at the current increment; PRST=1; BUSY=1. Counts strobes. When the count reaches RST_STB, PRST drops, ACK pulses if a request is pending, and the FSM goes to RUN.
- RUN: BUSY=0, PRST=0. REQ=1 latches MODE[c] and goes to PEND.
- PEND: BUSY=1. On the next raw strobe, load the new increment, clear the accumulator and strobe counter, set PRST=1, and go to HOLD.
- REQ in any state other than RUN is ignored: no latch, no ACK.

Channels are fully independent; simultaneous REQs on different channels are each serviced.

## Timing
- PCE is registered: PCE=1 in the cycle after the add carries.
- Reset values, in the cycle after RST is sampled high:
  - acc=0, inc=DEFAULT_MODE entry, state=HOLD, counter=0
  - PCE=0, PRST=1, BUSY=1, ACK=0, FREQ=0
- RST mid-operation aborts PEND/HOLD with no ACK.
- The power-up HOLD→RUN transition never pulses ACK.
- Mode-change latency: REQ→PEND in 1 cycle; PEND→HOLD on the first strobe; HOLD lasts RST_STB strobes; ACK and the PRST fall occur in the same cycle.
- PCE keeps toggling throughout HOLD so downstream logic sees its clock enable while in reset.
- The old-rate strobe that triggers PEND→HOLD is still emitted on PCE. The first new-rate strobe follows no earlier than 1 cycle later.
- Mode equal to the current mode is still a full change: the PRST sequence runs and ACK is issued.

## Configuration
- PCKENGEN_FREQ_EN defined:
  - A free-running gate counter wraps every GATE_CYC cycles.
  - Each channel counts its PCE strobes; at the gate wrap FREQ[c] <= count and the count restarts at 0.
  - The count saturates at 2^28-1.
  - Strobes in the wrap cycle count toward the new window.
- PCKENGEN_FREQ_EN undefined: FREQ port and all counters absent.

## Structure
- Package pckengen_pkg holds the mode typedef (2-bit enum VGA/P480/SVGA/XGA), the increment lookup function (scaled to ACC_W), and the FSM state enum.
- Sub-module pckengen_ch implements one channel: accumulator, FSM, and optional frequency counter.
- The top instantiates NCH copies with a generate loop and shares one gate counter across them.

## Test plan
- Reset with DEFAULT_MODE=0:
  - PRST=1 and BUSY=1 until 16 strobes have occurred, then PRST=0; no ACK.
  - Over 125000 cycles, PCE count is 25175 ±1.
- Channel 0 in RUN, REQ=1 with MODE=3:
  - BUSY rises 1 cycle later; PRST rises on the next old-rate strobe.
  - ACK pulses once after 16 new-rate strobes.
  - Rate then measures 65000 ±1 per 125000 cycles.
- REQ asserted during PEND and during HOLD → ignored; exactly one ACK; mode stays the first request.
- Simultaneous REQ on channels 0 (mode 1) and 1 (mode 2) → both ACK independently; rates 27000 and 40000 ±1 per 125000 cycles.
- RST pulsed mid-HOLD of a mode-3 change → channel returns to DEFAULT_MODE with PRST=1; no ACK.
- PCKENGEN_FREQ_EN with GATE_CYC=125000:
  - Mode 2 gives FREQ = 40000 ±1 after the second window.
  - FREQ is 0 before the first window wrap.

Source files
------------

// File: rtl/pckengen_pkg.sv
// pckengen_pkg: shared types and the mode-to-increment lookup for the
// multi-channel pixel-clock-enable generator.
package pckengen_pkg;

  // Selectable video pixel rates.
  typedef enum logic [1:0] {
    VGA  = 2'd0,  // 25.175 MHz
    P480 = 2'd1,  // 27.000 MHz
    SVGA = 2'd2,  // 40.000 MHz
    XGA  = 2'd3   // 65.000 MHz
  } mode_e;

  // Per-channel sequencing states.
  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,  // pixel reset asserted, waiting for enough new-rate strobes
    ST_RUN  = 2'd1,  // steady state, accepts mode-change requests
    ST_PEND = 2'd2   // request latched, waiting for an old-rate strobe to switch
  } ch_state_e;

  localparam int FREQ_W = 28;

  // Increments for a 32-bit accumulator: round(f / 125 MHz * 2^32).
  localparam logic [63:0] INC32_VGA  = 64'd865006413;
  localparam logic [63:0] INC32_P480 = 64'd927712936;
  localparam logic [63:0] INC32_SVGA = 64'd1374389535;
  localparam logic [63:0] INC32_XGA  = 64'd2233382994;

  // Increment for mode m, rescaled from the 32-bit table to acc_w bits.
  // The caller truncates the result to its accumulator width.
  function automatic logic [63:0] mode_inc(input mode_e m, input int acc_w);
    logic [63:0] base;
    case (m)
      VGA:     base = INC32_VGA;
      P480:    base = INC32_P480;
      SVGA:    base = INC32_SVGA;
      XGA:     base = INC32_XGA;
      default: base = INC32_VGA;
    endcase
    if (acc_w >= 32) mode_inc = base << (acc_w - 32);
    else             mode_inc = base >> (32 - acc_w);
  endfunction

endpackage

// File: rtl/pckengen_ch.sv
// pckengen_ch: one pixel-clock-enable channel. Phase accumulator whose carry
// is the raw strobe, plus the HOLD/RUN/PEND sequencer that drives PRST around
// every rate change. Optional strobe counter under PCKENGEN_FREQ_EN.
//
// Handshake: req_i is a single-cycle request honoured only in RUN; ack_o is a
// single-cycle pulse coinciding with the PRST fall that ends that request's
// HOLD. Requests seen in HOLD or PEND are dropped and never acknowledged.
module pckengen_ch
  import pckengen_pkg::*;
#(
  parameter int         ACC_W        = 32,
  parameter int         RST_STB      = 16,
  parameter logic [1:0] DEFAULT_MODE = 2'd0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic [1:0]          mode_i,
`ifdef PCKENGEN_FREQ_EN
  input  logic                gate_wrap_i,
  output logic [FREQ_W-1:0]   freq_o,
`endif
  output logic                ack_o,
  output logic                busy_o,
  output logic                pce_o,
  output logic                prst_o
);

  localparam int               CNT_W    = $clog2(RST_STB + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_STB);
  localparam logic [ACC_W-1:0] DEF_INC  = ACC_W'(mode_inc(mode_e'(DEFAULT_MODE), ACC_W));

  ch_state_e        state_q;
  mode_e            mode_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] inc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pce_q;
  logic             prst_q;
  logic             busy_q;
  logic             ack_q;
  logic             ack_pend_q;

  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_d;
  logic             carry;
  logic [CNT_W-1:0] cnt_d;
  logic [ACC_W-1:0] new_inc;

  // Accumulator add; its carry-out is the raw strobe.
  assign sum     = {1'b0, acc_q} + {1'b0, inc_q};
  assign acc_d   = sum[ACC_W-1:0];
  assign carry   = sum[ACC_W];
  assign cnt_d   = cnt_q + CNT_W'(1);
  assign new_inc = ACC_W'(mode_inc(mode_q, ACC_W));

  // Accumulator, strobe register and the channel sequencer with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_HOLD;
      mode_q     <= mode_e'(DEFAULT_MODE);
      acc_q      <= '0;
      inc_q      <= DEF_INC;
      cnt_q      <= '0;
      pce_q      <= 1'b0;
      prst_q     <= 1'b1;
      busy_q     <= 1'b1;
      ack_q      <= 1'b0;
      ack_pend_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      pce_q <= carry;
      ack_q <= 1'b0;
      case (state_q)
        ST_HOLD: begin
          if (carry) begin
            if (cnt_d == CNT_LAST) begin
              // Power-up HOLD has no pending request, so it never acknowledges.
              state_q    <= ST_RUN;
              prst_q     <= 1'b0;
              busy_q     <= 1'b0;
              ack_q      <= ack_pend_q;
              ack_pend_q <= 1'b0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        ST_RUN: begin
          if (req_i) begin
            mode_q     <= mode_e'(mode_i);
            state_q    <= ST_PEND;
            busy_q     <= 1'b1;
            ack_pend_q <= 1'b1;
          end
        end
        ST_PEND: begin
          // Switch on an old-rate strobe; that strobe still reaches pce_q.
          if (carry) begin
            inc_q   <= new_inc;
            acc_q   <= '0;
            cnt_q   <= '0;
            prst_q  <= 1'b1;
            state_q <= ST_HOLD;
          end
        end
        default: begin
          state_q <= ST_HOLD;
          prst_q  <= 1'b1;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign ack_o  = ack_q;
  assign busy_o = busy_q;
  assign pce_o  = pce_q;
  assign prst_o = prst_q;

`ifdef PCKENGEN_FREQ_EN
  logic [FREQ_W-1:0] fcnt_q;
  logic [FREQ_W-1:0] freq_q;

  // Saturating strobe count per gate window; a strobe in the wrap cycle opens the new window.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fcnt_q <= '0;
      freq_q <= '0;
    end else if (gate_wrap_i) begin
      freq_q <= fcnt_q;
      fcnt_q <= FREQ_W'(pce_q);
    end else if (pce_q && (fcnt_q != {FREQ_W{1'b1}})) begin
      fcnt_q <= fcnt_q + FREQ_W'(1);
    end
  end

  assign freq_o = freq_q;
`endif

endmodule

// File: rtl/pckengen.sv
// pckengen: multi-channel fractional pixel-clock-enable generator on SYSCLK.
// NCH independent pckengen_ch channels. Define PCKENGEN_FREQ_EN to add the
// shared gate counter and the per-channel FREQ measurement outputs.
module pckengen
  import pckengen_pkg::*;
#(
  parameter int NCH          = 2,
  parameter int ACC_W        = 32,
  parameter int RST_STB      = 16,
  parameter int DEFAULT_MODE = 0
`ifdef PCKENGEN_FREQ_EN
  ,
  parameter int GATE_CYC     = 125000000
`endif
) (
  input  logic                  SYSCLK,
  input  logic                  RST,
  input  logic [2*NCH-1:0]      MODE,
  input  logic [NCH-1:0]        REQ,
`ifdef PCKENGEN_FREQ_EN
  output logic [NCH*FREQ_W-1:0] FREQ,
`endif
  output logic [NCH-1:0]        ACK,
  output logic [NCH-1:0]        BUSY,
  output logic [NCH-1:0]        PCE,
  output logic [NCH-1:0]        PRST
);

`ifdef PCKENGEN_FREQ_EN
  logic [31:0] gate_q;
  logic        gate_wrap;

  assign gate_wrap = (gate_q == 32'(GATE_CYC - 1));

  // Free-running measurement gate shared by all channels.
  always_ff @(posedge SYSCLK) begin
    if (RST)            gate_q <= '0;
    else if (gate_wrap) gate_q <= '0;
    else                gate_q <= gate_q + 32'd1;
  end
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    pckengen_ch #(
      .ACC_W        (ACC_W),
      .RST_STB      (RST_STB),
      .DEFAULT_MODE (2'(DEFAULT_MODE))
    ) u_ch (
      .clk_i       (SYSCLK),
      .rst_i       (RST),
      .req_i       (REQ[c]),
      .mode_i      (MODE[2*c+1:2*c]),
`ifdef PCKENGEN_FREQ_EN
      .gate_wrap_i (gate_wrap),
      .freq_o      (FREQ[c*FREQ_W +: FREQ_W]),
`endif
      .ack_o       (ACK[c]),
      .busy_o      (BUSY[c]),
      .pce_o       (PCE[c]),
      .prst_o      (PRST[c])
    );
  end

endmodule

// File: tb/tb_pckengen.sv
// tb_pckengen: directed bench for pckengen (NCH=2, RST_STB=16, DEFAULT_MODE=0).
// Rates are measured over WIN=5000 SYSCLK cycles: expected strobe counts are
// f/125 MHz * 5000 (VGA 1007, P480 1080, SVGA 1600, XGA 2600), +/-1.
module tb_pckengen;

  localparam int NCH  = 2;
  localparam int WIN  = 5000;
  localparam int GATE = 5000;

  typedef struct {
    logic [1:0] mode;
    int         exp_rate;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mode;
  logic [1:0] req;
  logic [1:0] ack, busy, pce, prst;
`ifdef PCKENGEN_FREQ_EN
  logic [2*28-1:0] freq;
`endif

  always #4 clk = ~clk;

  pckengen #(
    .NCH          (NCH),
    .ACC_W        (32),
    .RST_STB      (16),
    .DEFAULT_MODE (0)
`ifdef PCKENGEN_FREQ_EN
    ,
    .GATE_CYC     (GATE)
`endif
  ) dut (
    .SYSCLK (clk),
    .RST    (rst),
    .MODE   (mode),
    .REQ    (req),
`ifdef PCKENGEN_FREQ_EN
    .FREQ   (freq),
`endif
    .ACK    (ack),
    .BUSY   (busy),
    .PCE    (pce),
    .PRST   (prst)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int pce_cnt [NCH];
  int ack_cnt [NCH];
  logic [31:0] exp_q[$];

  initial begin
    for (int c = 0; c < NCH; c++) begin
      pce_cnt[c] = 0;
      ack_cnt[c] = 0;
    end
  end

  // Running strobe and acknowledge tallies, sampled mid-cycle.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (pce[c] === 1'b1) pce_cnt[c] = pce_cnt[c] + 1;
      if (ack[c] === 1'b1) ack_cnt[c] = ack_cnt[c] + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pops the expected count from exp_q and compares with a +/-1 tolerance.
  task automatic check_rate(input string name, input int act);
    int exp;
    exp = int'(exp_q.pop_front());
    checks++;
    if (act < exp - 1 || act > exp + 1) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d +/-1", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_bit(input int sel, input int c);
    case (sel)
      0:       return ack[c];
      1:       return busy[c];
      2:       return pce[c];
      default: return prst[c];
    endcase
  endfunction

  // Waits for a signal bit (0 ack, 1 busy, 2 pce, 3 prst) to reach val.
  task automatic wait_bit(input int sel, input int c, input logic val,
                          input int budget, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (get_bit(sel, c) === val) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout after %0d cycles", name, budget);
    end
  endtask

  // Ticks until PRST[c] falls, counting PCE seen while PRST was still high.
  task automatic hold_count(input int c, input string name, output int n);
    bit found;
    n     = 0;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (prst[c] === 1'b0) begin
        found = 1'b1;
        break;
      end
      if (pce[c] === 1'b1) n++;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s: PRST never fell", name);
    end
  endtask

  task automatic measure(output int n0, output int n1);
    int b0, b1;
    b0 = pce_cnt[0];
    b1 = pce_cnt[1];
    repeat (WIN) tick();
    n0 = pce_cnt[0] - b0;
    n1 = pce_cnt[1] - b1;
  endtask

  // Full mode change on channel c with the latency checks along the way.
  task automatic do_change(input int c, input logic [1:0] m, input int exp_rate);
    int a0, n, r0, r1;
    a0 = ack_cnt[c];
    mode[2*c +: 2] = m;
    req[c] = 1'b1;
    tick();
    req[c] = 1'b0;
    check("busy_rise", busy[c], 1);
    check("prst_low_in_pend", prst[c], 0);
    wait_bit(3, c, 1'b1, 40, "prst_rise_wait");
    check("old_strobe_at_prst_rise", pce[c], 1);
    tick();
    check("gap_after_switch", pce[c], 0);
    hold_count(c, "hold", n);
    check("hold_strobes", n, 15);
    check("pce_at_prst_fall", pce[c], 1);
    check("ack_at_prst_fall", ack[c], 1);
    check("busy_after_hold", busy[c], 0);
    measure(r0, r1);
    exp_q.push_back(32'(exp_rate));
    check_rate("rate_after_change", (c == 0) ? r0 : r1);
    check("ack_once", ack_cnt[c] - a0, 1);
  endtask

  // ---------------- test ----------------
  vec_t tbl [5];

  initial begin
    int n, r0, r1, a0, a1;
    bit both;

    tbl[0] = '{mode: 2'd3, exp_rate: 2600};
    tbl[1] = '{mode: 2'd0, exp_rate: 1007};
    tbl[2] = '{mode: 2'd2, exp_rate: 1600};
    tbl[3] = '{mode: 2'd1, exp_rate: 1080};
    tbl[4] = '{mode: 2'd1, exp_rate: 1080};  // same mode again: still a full change

    rst  = 1'b1;
    mode = 4'd0;
    req  = 2'b00;
    repeat (3) tick();

    // Reset values.
    check("rst_pce", pce, 0);
    check("rst_prst", prst, 3);
    check("rst_busy", busy, 3);
    check("rst_ack", ack, 0);
    rst = 1'b0;

    // Power-up HOLD: 16 strobes, PRST falls, no ACK.
    hold_count(0, "powerup_hold", n);
    check("powerup_hold_strobes", n, 15);
    check("powerup_pce_at_fall", pce[0], 1);
    check("powerup_prst_both", prst, 0);
    check("powerup_busy_both", busy, 0);
    check("powerup_no_ack", ack, 0);
`ifdef PCKENGEN_FREQ_EN
    check("freq0_before_wrap", int'(freq[27:0]), 0);
    check("freq1_before_wrap", int'(freq[55:28]), 0);
`endif
    measure(r0, r1);
    exp_q.push_back(32'd1007);
    check_rate("powerup_rate_ch0", r0);
    check("powerup_ack_count0", ack_cnt[0], 0);
    check("powerup_ack_count1", ack_cnt[1], 0);

    // Table of mode changes on channel 0.
    for (int i = 0; i < 5; i++) begin
      do_change(0, tbl[i].mode, tbl[i].exp_rate);
    end

    // REQ during PEND and during HOLD is ignored.
    a0 = ack_cnt[0];
    mode[1:0] = 2'd2;
    req[0] = 1'b1;
    tick();
    mode[1:0] = 2'd3;
    tick();                 // this REQ is sampled while in PEND
    req[0] = 1'b0;
    wait_bit(3, 0, 1'b1, 40, "ign_prst_rise_wait");
    repeat (3) tick();
    check("ign_in_hold", prst[0], 1);
    mode[1:0] = 2'd0;
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    wait_bit(0, 0, 1'b1, 400, "ign_ack_wait");
    check("ign_prst_at_ack", prst[0], 0);
    measure(r0, r1);
    exp_q.push_back(32'd1600);
    check_rate("ign_rate_first_req", r0);
    check("ign_ack_once", ack_cnt[0] - a0, 1);

    // Simultaneous requests on both channels.
    a0 = ack_cnt[0];
    a1 = ack_cnt[1];
    mode = {2'd2, 2'd1};
    req  = 2'b11;
    tick();
    req  = 2'b00;
    check("sim_busy_both", busy, 3);
    both = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (ack_cnt[0] != a0 && ack_cnt[1] != a1) begin
        both = 1'b1;
        break;
      end
      tick();
    end
    check("sim_both_acked", int'(both), 1);
    measure(r0, r1);
    exp_q.push_back(32'd1080);
    exp_q.push_back(32'd1600);
    check_rate("sim_rate_ch0", r0);
    check_rate("sim_rate_ch1", r1);
    check("sim_ack0_once", ack_cnt[0] - a0, 1);
    check("sim_ack1_once", ack_cnt[1] - a1, 1);

`ifdef PCKENGEN_FREQ_EN
    repeat (2 * GATE) tick();
    exp_q.push_back(32'd1600);
    check_rate("freq_ch1_svga", int'(freq[55:28]));
    exp_q.push_back(32'd1080);
    check_rate("freq_ch0_p480", int'(freq[27:0]));
`endif

    // RST pulsed mid-HOLD of a mode-3 change.
    a0 = ack_cnt[0];
    a1 = ack_cnt[1];
    mode[1:0] = 2'd3;
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    wait_bit(3, 0, 1'b1, 40, "rst_prst_rise_wait");
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_pce", pce, 0);
    check("midrst_prst", prst, 3);
    check("midrst_busy", busy, 3);
    check("midrst_ack", ack, 0);
    hold_count(0, "midrst_hold", n);
    check("midrst_hold_strobes", n, 15);
    check("midrst_no_ack_at_fall", ack[0], 0);
    measure(r0, r1);
    exp_q.push_back(32'd1007);
    exp_q.push_back(32'd1007);
    check_rate("midrst_rate_ch0", r0);
    check_rate("midrst_rate_ch1", r1);
    check("midrst_ack0_none", ack_cnt[0] - a0, 0);
    check("midrst_ack1_none", ack_cnt[1] - a1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
